seq_mag_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator; successor to the fixed 4-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, in unsigned or two's-complement signed mode.
- Stops early at the first differing digit and reports EQ/GT/LT with a start/done handshake.
- Sits between operand registers and control logic that can tolerate variable latency in exchange for a short critical path.

---
 rtl/seq_mag_cmp_pkg.sv | 25 ++
 rtl/seq_mag_comparator_digit_compare.sv | 17 +
 rtl/seq_mag_comparator.sv | 130 +++++++++++++
 tb/tb_seq_mag_comparator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mag_cmp_pkg.sv
// Shared types and helpers for the multi-cycle magnitude comparator.
// State and result encodings plus the digit-pointer width calculation.
package seq_mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    EQ,
    GT,
    LT
  } cmp_result_t;

  // Bits needed to hold a digit index 0..n-1, never less than one bit.
  function automatic int ptr_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_mag_comparator_digit_compare.sv
// Combinational DIGIT-bit magnitude cell; the multi-bit form of the
// single-bit comparator cell used by the original fixed-width comparator.
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             d_eq,
  output logic             d_gt,
  output logic             d_lt
);

  assign d_eq = (x == y);
  assign d_gt = (x > y);
  assign d_lt = (x < y);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit and a
// start/done handshake; signed mode is handled by flipping operand MSBs.
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  import seq_mag_cmp_pkg::*;

  localparam int NDIG = WIDTH / DIGIT;
  localparam int PW   = ptr_width(NDIG);

  generate
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
      $fatal(1, "seq_mag_comparator: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic [WIDTH-1:0]  sign_mask;
  logic [WIDTH-1:0]  a_shift, b_shift;
  logic [DIGIT-1:0]  a_dig, b_dig;
  logic              d_eq, d_gt, d_lt;
  cmp_result_t       dig_res;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sign_mask = signed_mode ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  assign a_shift = a_q >> (DIGIT * int'(ptr_q));
  assign b_shift = b_q >> (DIGIT * int'(ptr_q));
  assign a_dig   = a_shift[DIGIT-1:0];
  assign b_dig   = b_shift[DIGIT-1:0];

  digit_compare #(.DIGIT(DIGIT)) u_digit (
    .x    (a_dig),
    .y    (b_dig),
    .d_eq (d_eq),
    .d_gt (d_gt),
    .d_lt (d_lt)
  );

  always_comb begin
    dig_res = LT;
    unique case ({d_eq, d_gt, d_lt})
      3'b100:  dig_res = EQ;
      3'b010:  dig_res = GT;
      default: dig_res = LT;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ptr_d   = ptr_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a ^ sign_mask;
          b_d     = b ^ sign_mask;
          ptr_d   = PW'(NDIG - 1);
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (dig_res != EQ) begin
          eq_d    = 1'b0;
          gt_d    = (dig_res == GT);
          lt_d    = (dig_res == LT);
          state_d = DONE;
        end else if (ptr_q == '0) begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ptr_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ptr_q   <= ptr_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = (state_q == COMPARE);
  assign done = (state_q == DONE);
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench: stimulus pushes expected {eq,gt,lt}, done cycle and busy
// length; per-DUT monitors pop and compare whenever done is seen.
module tb_seq_mag_comparator;

  typedef struct {
    int         cyc;
    logic [2:0] res;
    int         k;
  } exp_t;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic        clk;
  logic        rst;
  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16, eq16, gt16, lt16;
  logic        start4, sm4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, eq4, gt4, lt4;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   busy_cnt16 = 0;
  int   busy_cnt4 = 0;
  exp_t q16[$];
  exp_t q4[$];

  seq_mag_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .eq(eq16), .gt(gt16), .lt(lt16)
  );

  seq_mag_comparator #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .eq(eq4), .gt(gt4), .lt(lt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt16 = 0;
    end else begin
      if (busy16) busy_cnt16++;
      if (done16) begin
        if (q16.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_done16: done=1 with nothing pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q16.pop_front();
          checkOutput("result16", {29'd0, eq16, gt16, lt16}, {29'd0, e.res});
          checkOutput("done_cycle16", cyc, e.cyc);
          checkOutput("busy_cycles16", busy_cnt16, e.k);
        end
        busy_cnt16 = 0;
      end
    end
  end

  // Monitor for the 4-bit, 1-bit-digit instance.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt4 = 0;
    end else begin
      if (busy4) busy_cnt4++;
      if (done4) begin
        if (q4.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_done4: done=1 with nothing pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q4.pop_front();
          checkOutput("result4", {29'd0, eq4, gt4, lt4}, {29'd0, e.res});
          checkOutput("done_cycle4", cyc, e.cyc);
          checkOutput("busy_cycles4", busy_cnt4, e.k);
        end
        busy_cnt4 = 0;
      end
    end
  end

  // Called just after a rising edge; start is seen on the following edge.
  task automatic applyStimulus(input logic sm, input logic [15:0] av, input logic [15:0] bv,
                               input int k, input logic [2:0] res);
    exp_t e;
    start16 = 1'b1;
    sm16    = sm;
    a16     = av;
    b16     = bv;
    e.cyc   = cyc + k + 1;
    e.res   = res;
    e.k     = k;
    q16.push_back(e);
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  task automatic applyStimulus4(input logic [3:0] av, input logic [3:0] bv,
                                input int k, input logic [2:0] res);
    exp_t e;
    start4 = 1'b1;
    sm4    = 1'b0;
    a4     = av;
    b4     = bv;
    e.cyc  = cyc + k + 1;
    e.res  = res;
    e.k    = k;
    q4.push_back(e);
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic drain16(input int budget);
    int n = 0;
    while ((q16.size() != 0 || busy16) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL timeout16: %0d results still pending after %0d cycles", q16.size(), budget);
      q16.delete();
    end
  endtask

  task automatic drain4(input int budget);
    int n = 0;
    while ((q4.size() != 0 || busy4) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL timeout4: %0d results still pending after %0d cycles", q4.size(), budget);
      q4.delete();
    end
  endtask

  initial begin
    int         kk;
    logic [2:0] rr;
    logic [3:0] xa, xb;
    rst = 1'b1;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    start4  = 1'b0; sm4  = 1'b0; a4  = '0; b4  = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs16", {27'd0, busy16, done16, eq16, gt16, lt16}, 32'd0);
    checkOutput("reset_outputs4", {27'd0, busy4, done4, eq4, gt4, lt4}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] directed 16-bit compares");
    applyStimulus(1'b0, 16'h1234, 16'h1234, 4, R_EQ);
    drain16(20);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("result_held", {29'd0, eq16, gt16, lt16}, {29'd0, R_EQ});
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'hA000, 16'h3FFF, 1, R_GT);
    drain16(20);
    applyStimulus(1'b1, 16'hA000, 16'h3FFF, 1, R_LT);
    drain16(20);
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1, R_LT);
    drain16(20);
    applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1, R_GT);
    drain16(20);
    applyStimulus(1'b1, 16'h8000, 16'h7FFF, 1, R_LT);
    drain16(20);
    applyStimulus(1'b1, 16'hF00F, 16'hF00F, 4, R_EQ);
    drain16(20);
    applyStimulus(1'b1, 16'hFFF3, 16'hFFF5, 4, R_LT);
    drain16(20);
    applyStimulus(1'b0, 16'h5678, 16'h5679, 4, R_LT);
    drain16(20);

    $display("[TB] start held through busy, back-to-back in DONE");
    begin
      exp_t e;
      start16 = 1'b1; sm16 = 1'b0; a16 = 16'h12F0; b16 = 16'h12E0;
      e.cyc = cyc + 4; e.res = R_GT; e.k = 3;
      q16.push_back(e);
      @(posedge clk); #1;
      a16 = 16'h0001; b16 = 16'h0002;
      e.cyc = cyc + 3 + 5; e.res = R_LT; e.k = 4;
      q16.push_back(e);
      repeat (3) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      start16 = 1'b0;
      a16 = 16'hFFFF; b16 = 16'h0000;
    end
    drain16(20);

    $display("[TB] reset mid-compare");
    start16 = 1'b1; sm16 = 1'b0; a16 = 16'h5555; b16 = 16'h5555;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_outputs", {27'd0, busy16, done16, eq16, gt16, lt16}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(1'b0, 16'h0010, 16'h0001, 3, R_GT);
    drain16(20);

    $display("[TB] WIDTH=4 DIGIT=1 spot checks and sweep");
    applyStimulus4(4'b0110, 4'b1100, 1, R_LT);
    drain4(20);
    applyStimulus4(4'b1101, 4'b1101, 4, R_EQ);
    drain4(20);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        xa = 4'(i);
        xb = 4'(j);
        kk = 4;
        for (int p = 3; p >= 0; p--) begin
          if (xa[p] != xb[p]) begin
            kk = 4 - p;
            break;
          end
        end
        rr = (i > j) ? R_GT : ((i < j) ? R_LT : R_EQ);
        applyStimulus4(xa, xb, kk, rr);
        drain4(20);
      end
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
